// File: rtl/platform_pkg.sv
// platform_pkg: descriptor type, legacy layout and shared constants for the platform layer
package platform_pkg;
  localparam int BLOCK_W_DEF = 16;
  localparam logic [11:0] TRANS_KEY_DEF = 12'h6DE;
  localparam logic [4:0] HIT_WALL = 5'd31;
  localparam int NUM_DEFAULT = 6;
  typedef struct packed {
    logic en;
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] w;
    logic signed [3:0] dx;
    logic [9:0] lo;
    logic [9:0] hi;
  } plat_desc_t;
  typedef enum logic {ST_IDLE, ST_UPD} mot_state_t;
  localparam plat_desc_t [0:NUM_DEFAULT-1] DEFAULT_LAYOUT = {
    plat_desc_t'{1'b1, 10'd16,  10'd132, 10'd144, 4'sd0, 10'd0, 10'd640},
    plat_desc_t'{1'b1, 10'd160, 10'd216, 10'd96,  4'sd0, 10'd0, 10'd640},
    plat_desc_t'{1'b1, 10'd100, 10'd300, 10'd64,  4'sd0, 10'd0, 10'd640},
    plat_desc_t'{1'b1, 10'd192, 10'd220, 10'd64,  4'sd0, 10'd0, 10'd640},
    plat_desc_t'{1'b1, 10'd400, 10'd180, 10'd128, 4'sd0, 10'd0, 10'd640},
    plat_desc_t'{1'b1, 10'd480, 10'd360, 10'd96,  4'sd0, 10'd0, 10'd640}
  };
  function automatic plat_desc_t default_desc(input int i);
    return i < NUM_DEFAULT ? DEFAULT_LAYOUT[3'(i % NUM_DEFAULT)] : '0;
  endfunction
endpackage

// File: rtl/platform_hit_detect.sv
// platform_hit_detect: per-descriptor hit compare with wall-first, lowest-index priority
module platform_hit_detect
  import platform_pkg::*;
#(
  parameter int NUM_PLAT = 8,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  plat_desc_t [NUM_PLAT-1:0] descs,
  output logic hit,
  output logic wall,
  output logic [4:0] idx,
  output logic [6:0] row,
  output logic [3:0] col
);
  localparam logic [10:0] BW = 11'(BLOCK_W);
  localparam logic [10:0] XR = 11'(H_RES - BLOCK_W);
  localparam logic [10:0] YB = 11'(V_RES - BLOCK_W);
  logic [10:0] xe, ye;
  assign xe = {1'b0, x};
  assign ye = {1'b0, y};
  always_comb begin
    wall = xe < BW || xe >= XR || ye < BW || ye >= YB;
    hit = wall;
    idx = HIT_WALL;
    row = 7'(ye % BW);
    col = 4'(xe % BW);
    for (int i = NUM_PLAT - 1; i >= 0; i--)
      if (!wall && descs[i].en && descs[i].w != 10'd0 &&
          ye >= {1'b0, descs[i].y0} && ye < {1'b0, descs[i].y0} + BW &&
          xe >= {1'b0, descs[i].x0} && xe < {1'b0, descs[i].x0} + {1'b0, descs[i].w}) begin
        hit = 1'b1;
        idx = 5'(i);
        row = 7'(ye - {1'b0, descs[i].y0} + BW);
        col = 4'((xe - {1'b0, descs[i].x0}) % BW);
      end
  end
endmodule

// File: rtl/platform_layer_engine.sv
// platform_layer_engine: descriptor table, per-frame motion FSM and 3-stage texture pipeline
module platform_layer_engine
  import platform_pkg::*;
#(
  parameter int NUM_PLAT = 8,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter logic [11:0] TRANS_KEY = TRANS_KEY_DEF,
  localparam int IW = $clog2(NUM_PLAT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic frame_tick,
  input  logic cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic cfg_en,
  input  logic [9:0] cfg_x0,
  input  logic [9:0] cfg_y0,
  input  logic [9:0] cfg_w,
  input  logic signed [3:0] cfg_dx,
  input  logic [9:0] cfg_lo,
  input  logic [9:0] cfg_hi,
  output logic tex_sel,
  output logic [6:0] tex_row,
  output logic [3:0] tex_col,
  input  logic [11:0] wall_rgb,
  input  logic [11:0] block_rgb,
  output logic [11:0] rgb_out,
  output logic platforms_on,
  output logic [4:0] hit_idx,
  output logic busy
);
  plat_desc_t [NUM_PLAT-1:0] tbl;
  mot_state_t state, state_nx;
  logic [IW-1:0] k;
  plat_desc_t cur, upd;
  logic signed [11:0] nx;
  logic move, bounce;
  logic hit, wall;
  logic [4:0] idx;
  logic [6:0] row;
  logic [3:0] col;
  logic s1_on, s2_on, s2_sel, opaque;
  logic [4:0] s1_idx, s2_idx;
  logic [11:0] texel;
  platform_hit_detect #(
    .NUM_PLAT(NUM_PLAT), .BLOCK_W(BLOCK_W), .H_RES(H_RES), .V_RES(V_RES)
  ) u_hit (
    .x(x), .y(y), .descs(tbl), .hit(hit), .wall(wall), .idx(idx), .row(row), .col(col)
  );
  assign busy = state == ST_UPD;
  always_comb begin
    state_nx = state == ST_IDLE ? (frame_tick ? ST_UPD : ST_IDLE)
                                : (k == IW'(NUM_PLAT - 1) ? ST_IDLE : ST_UPD);
    cur = tbl[k];
    nx = $signed({2'b00, cur.x0}) + $signed({{8{cur.dx[3]}}, cur.dx});
    move = cur.en && cur.dx != 4'sd0;
    bounce = nx < $signed({2'b00, cur.lo}) ||
             nx + $signed({2'b00, cur.w}) > $signed({2'b00, cur.hi});
    upd = cur;
    upd.dx = move && bounce ? -cur.dx : cur.dx;
    upd.x0 = move && !bounce ? nx[9:0] : cur.x0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      k <= '0;
      for (int i = 0; i < NUM_PLAT; i++) tbl[i] <= default_desc(i);
    end else begin
      state <= state_nx;
      k <= state == ST_UPD && state_nx == ST_UPD ? k + 1'b1 : '0;
      for (int i = 0; i < NUM_PLAT; i++)
        if (cfg_we && cfg_idx == IW'(i))
          tbl[i] <= plat_desc_t'{cfg_en, cfg_x0, cfg_y0, cfg_w, cfg_dx, cfg_lo, cfg_hi};
        else if (state == ST_UPD && k == IW'(i))
          tbl[i] <= upd;
    end
  assign texel = s2_sel ? block_rgb : wall_rgb;
  assign opaque = s2_on && texel != TRANS_KEY;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tex_sel <= 1'b0;
      tex_row <= '0;
      tex_col <= '0;
      s1_on <= 1'b0;
      s1_idx <= HIT_WALL;
      s2_sel <= 1'b0;
      s2_on <= 1'b0;
      s2_idx <= HIT_WALL;
      rgb_out <= '0;
      platforms_on <= 1'b0;
      hit_idx <= HIT_WALL;
    end else begin
      tex_sel <= hit & ~wall;
      tex_row <= row;
      tex_col <= col;
      s1_on <= hit & video_on;
      s1_idx <= idx;
      s2_sel <= tex_sel;
      s2_on <= s1_on;
      s2_idx <= s1_idx;
      rgb_out <= opaque ? texel : '0;
      platforms_on <= opaque;
      hit_idx <= s2_idx;
    end
endmodule

// File: tb/tb_platform_layer_engine.sv
// tb_platform_layer_engine: directed scoreboard bench for the platform layer engine
module tb_platform_layer_engine;
  import platform_pkg::*;
  typedef struct packed {
    logic on;
    logic [11:0] rgb;
    logic [4:0] idx;
  } exp_t;
  logic clk = 0, rst_n = 1, video_on = 0, frame_tick = 0, cfg_we = 0, cfg_en = 0;
  logic [9:0] x = 0, y = 0, cfg_x0 = 0, cfg_y0 = 0, cfg_w = 0, cfg_lo = 0, cfg_hi = 0;
  logic [2:0] cfg_idx = 0;
  logic signed [3:0] cfg_dx = 0;
  logic [11:0] wall_rgb = 0, block_rgb = 0;
  logic tex_sel, platforms_on, busy;
  logic [6:0] tex_row;
  logic [3:0] tex_col;
  logic [11:0] rgb_out;
  logic [4:0] hit_idx;
  int checks = 0, errors = 0, nb;
  exp_t sb[$];
  exp_t mon_e;
  logic issue = 0;
  logic [2:0] vp;
  always #5 clk = ~clk;
  platform_layer_engine dut (
    .clk(clk), .rst_n(rst_n), .video_on(video_on), .x(x), .y(y), .frame_tick(frame_tick),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0),
    .cfg_w(cfg_w), .cfg_dx(cfg_dx), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
    .tex_sel(tex_sel), .tex_row(tex_row), .tex_col(tex_col),
    .wall_rgb(wall_rgb), .block_rgb(block_rgb), .rgb_out(rgb_out),
    .platforms_on(platforms_on), .hit_idx(hit_idx), .busy(busy)
  );
  function automatic logic [11:0] wall_rom(input logic [6:0] r, input logic [3:0] c);
    return {4'h4, r[3:0] ^ 4'hC, c ^ 4'hC};
  endfunction
  function automatic logic [11:0] block_rom(input logic [6:0] r, input logic [3:0] c);
    return (r == 7'd24 && c == 4'd4) ? 12'h6DE : {3'b101, r[4:0], c};
  endfunction
  always @(posedge clk) begin
    wall_rgb <= wall_rom(tex_row, tex_col);
    block_rgb <= block_rom(tex_row, tex_col);
  end
  always @(posedge clk or negedge rst_n) vp <= !rst_n ? 3'b0 : {vp[1:0], issue};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && vp[2]) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel: output with empty scoreboard");
      end else begin
        mon_e = sb.pop_front();
        chk("pix_on", platforms_on, mon_e.on);
        chk("pix_rgb", rgb_out, mon_e.rgb);
        if (mon_e.on) chk("pix_idx", hit_idx, mon_e.idx);
      end
    end
  task automatic pix(input int px, input int py, input logic von, input logic on,
                     input logic [11:0] rgb, input logic [4:0] idx);
    x = 10'(px);
    y = 10'(py);
    video_on = von;
    issue = 1;
    sb.push_back(exp_t'{on, rgb, idx});
    @(negedge clk);
    issue = 0;
    video_on = 0;
  endtask
  task automatic cfg_set(input int idx, input logic en, input int x0, input int y0, input int w,
                         input int dx, input int lo, input int hi);
    cfg_we = 1;
    cfg_idx = 3'(idx);
    cfg_en = en;
    cfg_x0 = 10'(x0);
    cfg_y0 = 10'(y0);
    cfg_w = 10'(w);
    cfg_dx = 4'(dx);
    cfg_lo = 10'(lo);
    cfg_hi = 10'(hi);
  endtask
  task automatic check_x0(input int e);
    pix(e - 1, 300, 1, 0, 12'h000, 5'd0);
    pix(e, 300, 1, 1, 12'hB00, 5'd2);
    pix(e + 63, 300, 1, 1, 12'hB0F, 5'd2);
  endtask
  task automatic tick_frame(input bit disturb, output int n);
    n = 0;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) n++;
      if (disturb && i == 0) frame_tick = 1;
      if (disturb && i == 2) cfg_set(2, 1, 200, 300, 64, 4, 96, 300);
      @(negedge clk);
      frame_tick = 0;
      cfg_we = 0;
    end
  endtask
  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_on", platforms_on, 0);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_idx", hit_idx, 31);
    chk("rst_busy", busy, 0);
    chk("rst_tex", {tex_sel, tex_row, tex_col}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pix(8, 200, 1, 1, 12'h444, 5'd31);
    pix(300, 100, 1, 0, 12'h000, 5'd0);
    pix(8, 200, 0, 0, 12'h000, 5'd0);
    pix(639, 479, 1, 1, 12'h433, 5'd31);
    pix(623, 240, 1, 0, 12'h000, 5'd0);
    pix(624, 240, 1, 1, 12'h4CC, 5'd31);
    pix(300, 15, 1, 1, 12'h430, 5'd31);
    pix(300, 16, 1, 0, 12'h000, 5'd0);
    pix(20, 140, 1, 0, 12'h000, 5'd0);
    chk("tex_sel", tex_sel, 1);
    chk("tex_row", tex_row, 24);
    chk("tex_col", tex_col, 4);
    pix(21, 140, 1, 1, 12'hB85, 5'd0);
    pix(159, 147, 1, 1, 12'hBFF, 5'd0);
    pix(160, 147, 1, 0, 12'h000, 5'd0);
    pix(16, 131, 1, 0, 12'h000, 5'd0);
    pix(200, 220, 1, 1, 12'hB48, 5'd1);
    cfg_set(0, 1, 3, 132, 144, 0, 0, 640);
    @(negedge clk);
    cfg_we = 0;
    pix(5, 140, 1, 1, 12'h409, 5'd31);
    pix(20, 141, 1, 1, 12'hB91, 5'd0);
    pix(147, 141, 1, 0, 12'h000, 5'd0);
    cfg_set(2, 1, 100, 300, 64, 4, 96, 172);
    @(negedge clk);
    cfg_we = 0;
    check_x0(100);
    tick_frame(0, nb); chk("busy_cycles", nb, 8); check_x0(104);
    tick_frame(0, nb); chk("busy_cycles", nb, 8); check_x0(108);
    tick_frame(0, nb); chk("busy_cycles", nb, 8); check_x0(108);
    tick_frame(0, nb); chk("busy_cycles", nb, 8); check_x0(104);
    tick_frame(1, nb); chk("busy_disturbed", nb, 8);
    chk("busy_idle", busy, 0);
    check_x0(200);
    repeat (5) @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    x = 8;
    y = 200;
    video_on = 1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_on", platforms_on, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_on", platforms_on, 0);
    chk("mid_rst_rgb", rgb_out, 0);
    chk("mid_rst_idx", hit_idx, 31);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tex", {tex_sel, tex_row, tex_col}, 0);
    video_on = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check_x0(100);
    pix(147, 141, 1, 1, 12'hB93, 5'd0);
    pix(20, 140, 1, 0, 12'h000, 5'd0);
    repeat (6) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
